multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Parametrised control FSM for the multicycle MIPS-subset CPU.
- Drives every datapath mux and write-enable from the latched instruction register.
- Adds four features:
  - memory wait-state handshake (fetch and data access stall on mem_ready)
  - illegal-opcode trap state
  - synchronous reset
  - cycle and retired-instruction counters
- Sits between the instruction register and the datapath, replacing the single-cycle-timing controller.

Parameters:
- COUNT_W, 32, width of cycle_count and instr_count; both wrap modulo 2^COUNT_W.
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready internally forced to 1 (every memory access completes in one cycle).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction register contents (valid from DECODE onward).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- mem_addr_sel  out  1  0 = PC, 1 = ALUOut.
- mem_we  out  1  data write (SW only).
- ir_we  out  1  latch fetched word into IR.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump {PC[31:28],instr[25:0],2'b00}, 3 = rs register value.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_src_b_zext  out  1  when 1 with alu_src_b=2, imm is zero-extended (XORI).
- alu_op  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT.
- branch_en  out  1  conditional PC write on ALU zero flag.
- branch_ne  out  1  invert zero condition (BNE).
- reg_we  out  1  register-file write.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = r31.
- reg_src  out  2  0 = ALUOut, 1 = memory data register, 2 = PC.
- illegal  out  1  held high in TRAP.
- cycle_count  out  COUNT_W  cycles since reset.
- instr_count  out  COUNT_W  retired instructions.

Behaviour:
- Reset (synchronous, active-high):
  - state = FETCH; both counters = 0.
  - All outputs are Moore-decoded from state + instr. During the reset cycle every strobe (mem_req, mem_we, ir_we, pc_we, reg_we, branch_en) is forced to 0.
  - Reset mid-operation aborts the instruction with no register or memory write after the reset edge.
- Default for every output not listed below: 0.
- Legal instructions:
  - opcode 0x23 LW, 0x2b SW, 0x02 J, 0x03 JAL, 0x04 BEQ, 0x05 BNE, 0x0E XORI, 0x08 ADDI.
  - opcode 0x00 with funct 0x20 ADD, 0x22 SUB, 0x2a SLT, 0x08 JR.
  - Anything else is illegal; R-type funct is decoded only when opcode = 0.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=1, alu_op=ADD.
  - ir_we=pc_we=mem_ready, pc_src=0.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut).
  - J: pc_we=1, pc_src=2, then FETCH.
  - JAL: same as J, plus reg_we=1, reg_dst=2, reg_src=2 (PC already +4), then FETCH.
  - Illegal: go to TRAP.
  - Otherwise: go to EXEC.
- EXEC:
  - BEQ/BNE: alu_src_a=1, alu_src_b=0, alu_op=SUB, branch_en=1, branch_ne=(BNE), pc_src=1, then FETCH.
  - JR: pc_we=1, pc_src=3, then FETCH.
  - LW/SW/ADDI: alu_src_a=1, alu_src_b=2, ADD.
  - XORI: alu_src_a=1, alu_src_b=2, alu_src_b_zext=1, XOR.
  - ADD/SUB/SLT: alu_src_a=1, alu_src_b=0, matching alu_op.
  - Next state: LW/SW go to MEM; all others go to WB.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we=(SW).
  - Holds while !mem_ready. The SW write strobe is asserted every wait cycle; memory commits only on the mem_ready cycle.
  - On mem_ready: LW goes to WB; SW goes to FETCH.
- WB:
  - reg_we=1, then FETCH.
  - LW: reg_dst=0, reg_src=1.
  - ADDI/XORI: reg_dst=0, reg_src=0.
  - R-type: reg_dst=1, reg_src=0.
- TRAP:
  - illegal=1; all strobes 0.
  - Exits only on reset.
- Counters:
  - cycle_count increments every non-reset cycle, including TRAP.
  - instr_count increments on each transition into FETCH from DECODE, EXEC, MEM or WB (never from FETCH itself or TRAP).
  - Both wrap silently.
- Latency with zero wait states: J/JAL 2, BEQ/BNE/JR 3, ADDI/XORI/R-type/SW 4, LW 5 cycles. Each memory wait cycle adds exactly 1.
- mem_ready is ignored outside FETCH and MEM.

Decomposition:
- Shared package holds:
  - opcode and funct constants
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - pc_src, alu_src_b, alu_op, reg_dst and reg_src encodings
- One sub-module: multicycle_op_decode (combinational). Maps instr to one-hot op class plus an illegal flag; shared by the next-state and output logic.

Test Plan:
- ADD $3,$1,$2 (0x00221820), mem_ready=1 → states F,D,E,W,F. In WB: reg_we=1, reg_dst=1; alu_op=ADD in EXEC; instr_count 0→1 after 4 cycles.
- LW with mem_ready low for 2 cycles in FETCH and 3 in MEM → ir_we high only on the ready cycle; WB reached at cycle 10; reg_src=1 in WB.
- BNE (opcode 0x05) → EXEC shows branch_en=1, branch_ne=1, pc_src=1, alu_op=SUB; back to FETCH after 3 cycles.
- JAL 0x0C000010 → DECODE shows pc_we=1, pc_src=2, reg_we=1, reg_dst=2, reg_src=2; next state FETCH.
- Opcode 0x3F → TRAP after DECODE; illegal stays 1 for 20 cycles with no strobes; cycle_count keeps counting, instr_count frozen; reset returns to FETCH with both counters 0.
- Reset asserted in MEM of SW with mem_ready=1 the same cycle → mem_we=0 that cycle; state FETCH next; no retire counted.
- MEM_HANDSHAKE=0 with mem_ready tied low → LW still completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM.
// Opcodes, functs, state enum, datapath mux selects and op class.
package multicycle_ctrl_fsm_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_e;

   typedef enum logic [1:0] {
      PC_ALU,
      PC_ALUOUT,
      PC_JUMP,
      PC_RS
   } pc_src_e;

   typedef enum logic [1:0] {
      B_RT,
      B_FOUR,
      B_IMM,
      B_IMM_SH2
   } alu_src_b_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_XOR = 3'd2,
      ALU_SLT = 3'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      DST_RT,
      DST_RD,
      DST_R31
   } reg_dst_e;

   typedef enum logic [1:0] {
      SRC_ALUOUT,
      SRC_MDR,
      SRC_PC
   } reg_src_e;

   // One-hot instruction class; all zero means illegal.
   typedef struct packed {
      logic lw;
      logic sw;
      logic j;
      logic jal;
      logic beq;
      logic bne;
      logic xori;
      logic addi;
      logic add;
      logic sub;
      logic slt;
      logic jr;
   } op_t;

   function automatic logic is_rtype_alu(op_t o);
      return o.add | o.sub | o.slt;
   endfunction

   function automatic logic is_mem(op_t o);
      return o.lw | o.sw;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction/handshake inputs and datapath control outputs.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_fsm_if #(
   parameter int COUNT_W = 32
);
   logic [31:0]        instr;
   logic               mem_ready;
   logic               mem_req;
   logic               mem_addr_sel;
   logic               mem_we;
   logic               ir_we;
   logic               pc_we;
   logic [1:0]         pc_src;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic               alu_src_b_zext;
   logic [2:0]         alu_op;
   logic               branch_en;
   logic               branch_ne;
   logic               reg_we;
   logic [1:0]         reg_dst;
   logic [1:0]         reg_src;
   logic               illegal;
   logic [COUNT_W-1:0] cycle_count;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  instr, mem_ready,
      output mem_req, mem_addr_sel, mem_we, ir_we, pc_we, pc_src,
      output alu_src_a, alu_src_b, alu_src_b_zext, alu_op,
      output branch_en, branch_ne, reg_we, reg_dst, reg_src,
      output illegal, cycle_count, instr_count
   );

   modport slave (
      output instr, mem_ready,
      input  mem_req, mem_addr_sel, mem_we, ir_we, pc_we, pc_src,
      input  alu_src_a, alu_src_b, alu_src_b_zext, alu_op,
      input  branch_en, branch_ne, reg_we, reg_dst, reg_src,
      input  illegal, cycle_count, instr_count
   );

endinterface

// File: rtl/multicycle_ctrl_fsm_op_decode.sv
// Instruction classifier: one-hot op class plus illegal flag.
// R-type funct is only looked at when the opcode is zero.
module multicycle_op_decode
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic [31:0] instr,
   output op_t         op,
   output logic        illegal
);

   logic [5:0] opc;
   logic [5:0] fn;
   logic       unused_bits;

   assign opc         = instr[31:26];
   assign fn          = instr[5:0];
   assign unused_bits = ^instr[25:6];

   always_comb begin
      op = '0;
      unique case (1'b1)
         (opc == OP_LW):   op.lw   = 1'b1;
         (opc == OP_SW):   op.sw   = 1'b1;
         (opc == OP_J):    op.j    = 1'b1;
         (opc == OP_JAL):  op.jal  = 1'b1;
         (opc == OP_BEQ):  op.beq  = 1'b1;
         (opc == OP_BNE):  op.bne  = 1'b1;
         (opc == OP_XORI): op.xori = 1'b1;
         (opc == OP_ADDI): op.addi = 1'b1;
         (opc == OP_RTYPE && fn == FN_ADD): op.add = 1'b1;
         (opc == OP_RTYPE && fn == FN_SUB): op.sub = 1'b1;
         (opc == OP_RTYPE && fn == FN_SLT): op.slt = 1'b1;
         (opc == OP_RTYPE && fn == FN_JR):  op.jr  = 1'b1;
         default: ;
      endcase
   end

   assign illegal = ~|op;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM with memory wait states,
// illegal-opcode trap and cycle/retired-instruction counters.
module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
#(
   parameter int COUNT_W       = 32,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   multicycle_ctrl_fsm_if.master bus
);

   state_e             state;
   state_e             nxt;
   op_t                op;
   logic               bad;
   logic               rdy;
   logic               retire;
   logic [COUNT_W-1:0] cyc_q;
   logic [COUNT_W-1:0] ret_q;

   logic       mem_req;
   logic       addr_sel;
   logic       mem_we;
   logic       ir_we;
   logic       pc_we;
   pc_src_e    pc_src;
   logic       src_a;
   alu_src_b_e src_b;
   logic       zext;
   alu_op_e    alu_op;
   logic       br_en;
   logic       br_ne;
   logic       reg_we;
   reg_dst_e   reg_dst;
   reg_src_e   reg_src;
   logic       trap;

   multicycle_op_decode u_dec (
      .instr   (bus.instr),
      .op      (op),
      .illegal (bad)
   );

   assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

   always_comb begin
      nxt = state;
      case (state)
         S_FETCH: begin
            if (rdy) nxt = S_DECODE;
         end
         S_DECODE: begin
            if (op.j | op.jal) nxt = S_FETCH;
            else if (bad)      nxt = S_TRAP;
            else               nxt = S_EXEC;
         end
         S_EXEC: begin
            if (op.beq | op.bne | op.jr) nxt = S_FETCH;
            else if (is_mem(op))         nxt = S_MEM;
            else                         nxt = S_WB;
         end
         S_MEM: begin
            if (rdy) nxt = op.lw ? S_WB : S_FETCH;
         end
         S_WB:    nxt = S_FETCH;
         S_TRAP:  nxt = S_TRAP;
         default: nxt = S_FETCH;
      endcase
   end

   assign retire = (nxt == S_FETCH) &&
                   (state != S_FETCH) && (state != S_TRAP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         state <= nxt;
         cyc_q <= cyc_q + COUNT_W'(1);
         if (retire) ret_q <= ret_q + COUNT_W'(1);
      end
   end

   always_comb begin
      mem_req  = 1'b0;
      addr_sel = 1'b0;
      mem_we   = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = PC_ALU;
      src_a    = 1'b0;
      src_b    = B_RT;
      zext     = 1'b0;
      alu_op   = ALU_ADD;
      br_en    = 1'b0;
      br_ne    = 1'b0;
      reg_we   = 1'b0;
      reg_dst  = DST_RT;
      reg_src  = SRC_ALUOUT;
      trap     = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            src_b   = B_FOUR;
            ir_we   = rdy;
            pc_we   = rdy;
         end
         S_DECODE: begin
            // ALUOut captures the branch target speculatively
            src_b = B_IMM_SH2;
            if (op.j | op.jal) begin
               pc_we  = 1'b1;
               pc_src = PC_JUMP;
            end
            if (op.jal) begin
               reg_we  = 1'b1;
               reg_dst = DST_R31;
               reg_src = SRC_PC;
            end
         end
         S_EXEC: begin
            unique case (1'b1)
               (op.beq | op.bne): begin
                  src_a  = 1'b1;
                  alu_op = ALU_SUB;
                  br_en  = 1'b1;
                  br_ne  = op.bne;
                  pc_src = PC_ALUOUT;
               end
               op.jr: begin
                  pc_we  = 1'b1;
                  pc_src = PC_RS;
               end
               (is_mem(op) | op.addi): begin
                  src_a = 1'b1;
                  src_b = B_IMM;
               end
               op.xori: begin
                  src_a  = 1'b1;
                  src_b  = B_IMM;
                  zext   = 1'b1;
                  alu_op = ALU_XOR;
               end
               is_rtype_alu(op): begin
                  src_a  = 1'b1;
                  alu_op = op.sub ? ALU_SUB :
                           op.slt ? ALU_SLT : ALU_ADD;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = op.sw;
         end
         S_WB: begin
            reg_we = 1'b1;
            if (op.lw)                 reg_src = SRC_MDR;
            else if (is_rtype_alu(op)) reg_dst = DST_RD;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
   end

   // Strobes are killed in the reset cycle so an aborted op has no effect
   assign bus.mem_req        = mem_req & ~reset;
   assign bus.mem_we         = mem_we  & ~reset;
   assign bus.ir_we          = ir_we   & ~reset;
   assign bus.pc_we          = pc_we   & ~reset;
   assign bus.reg_we         = reg_we  & ~reset;
   assign bus.branch_en      = br_en   & ~reset;
   assign bus.mem_addr_sel   = addr_sel;
   assign bus.pc_src         = pc_src;
   assign bus.alu_src_a      = src_a;
   assign bus.alu_src_b      = src_b;
   assign bus.alu_src_b_zext = zext;
   assign bus.alu_op         = alu_op;
   assign bus.branch_ne      = br_ne;
   assign bus.reg_dst        = reg_dst;
   assign bus.reg_src        = reg_src;
   assign bus.illegal        = trap;
   assign bus.cycle_count    = cyc_q;
   assign bus.instr_count    = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Table-driven bench for multicycle_ctrl_fsm with a scoreboard queue.
// Second instance covers MEM_HANDSHAKE=0 with mem_ready tied low.
module tb_multicycle_ctrl_fsm;

   logic clk;
   logic rst;
   logic rst2;

   multicycle_ctrl_fsm_if #(.COUNT_W(32)) bus1 ();
   multicycle_ctrl_fsm_if #(.COUNT_W(32)) bus2 ();

   multicycle_ctrl_fsm #(.COUNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus1)
   );

   multicycle_ctrl_fsm #(.COUNT_W(32), .MEM_HANDSHAKE(1'b0)) dut2 (
      .clk   (clk),
      .reset (rst2),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      logic [31:0] ins;
      bit          rdy;
      logic [21:0] ctl;
      bit          ret;
   } vec_t;

   typedef struct {
      logic [21:0] ctl;
      logic [31:0] cyc;
      logic [31:0] ic;
      int          row;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] I_ADD  = 32'h0022_1820;
   localparam logic [31:0] I_SUB  = 32'h0022_1822;
   localparam logic [31:0] I_SLT  = 32'h0022_182A;
   localparam logic [31:0] I_JR   = 32'h03E0_0008;
   localparam logic [31:0] I_ADDU = 32'h0022_1821;
   localparam logic [31:0] I_LW   = 32'h8C22_0004;
   localparam logic [31:0] I_SW   = 32'hAC22_0004;
   localparam logic [31:0] I_BEQ  = 32'h1022_0003;
   localparam logic [31:0] I_BNE  = 32'h1422_0003;
   localparam logic [31:0] I_J    = 32'h0800_0010;
   localparam logic [31:0] I_JAL  = 32'h0C00_0010;
   localparam logic [31:0] I_ADDI = 32'h2022_0005;
   localparam logic [31:0] I_XORI = 32'h3822_0005;
   localparam logic [31:0] I_BAD  = 32'hFC00_0000;

   logic [21:0] c_f1, c_f0, c_d, c_dj, c_djal;
   logic [21:0] c_eadd, c_esub, c_eslt, c_eimm, c_exori;
   logic [21:0] c_ebeq, c_ebne, c_ejr;
   logic [21:0] c_mlw, c_msw, c_mrst;
   logic [21:0] c_wbr, c_wblw, c_wbi, c_trap;

   logic [21:0] act1;
   assign act1 = {bus1.mem_req, bus1.mem_addr_sel, bus1.mem_we,
                  bus1.ir_we, bus1.pc_we, bus1.pc_src,
                  bus1.alu_src_a, bus1.alu_src_b, bus1.alu_src_b_zext,
                  bus1.alu_op, bus1.branch_en, bus1.branch_ne,
                  bus1.reg_we, bus1.reg_dst, bus1.reg_src, bus1.illegal};

   function automatic logic [21:0] cw(
      input int mr, input int as, input int mw, input int iw,
      input int pw, input int ps, input int sa, input int sb_,
      input int zx, input int ao, input int be, input int bn,
      input int rw, input int rd, input int rs, input int il);
      return {1'(mr), 1'(as), 1'(mw), 1'(iw), 1'(pw), 2'(ps),
              1'(sa), 2'(sb_), 1'(zx), 3'(ao), 1'(be), 1'(bn),
              1'(rw), 2'(rd), 2'(rs), 1'(il)};
   endfunction

   task automatic add(input bit r, input logic [31:0] i, input bit m,
                      input logic [21:0] c, input bit ret);
      vec_t v;
      v.rst = r;
      v.ins = i;
      v.rdy = m;
      v.ctl = c;
      v.ret = ret;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int row,
                        input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
      end
   endtask

   // Three-cycle R/I-type prefix: fetch, decode, exec
   task automatic fde(input logic [31:0] i, input logic [21:0] e);
      add(0, i, 1, c_f1, 0);
      add(0, i, 1, c_d, 0);
      add(0, i, 1, e, 0);
   endtask

   logic [31:0] ecyc;
   logic [31:0] eic;
   exp_t        e;
   int          n;

   initial begin
      c_f1    = cw(1,0,0,1,1,0,0,1,0,0,0,0,0,0,0,0);
      c_f0    = cw(1,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0);
      c_d     = cw(0,0,0,0,0,0,0,3,0,0,0,0,0,0,0,0);
      c_dj    = cw(0,0,0,0,1,2,0,3,0,0,0,0,0,0,0,0);
      c_djal  = cw(0,0,0,0,1,2,0,3,0,0,0,0,1,2,2,0);
      c_eadd  = cw(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0);
      c_esub  = cw(0,0,0,0,0,0,1,0,0,1,0,0,0,0,0,0);
      c_eslt  = cw(0,0,0,0,0,0,1,0,0,3,0,0,0,0,0,0);
      c_eimm  = cw(0,0,0,0,0,0,1,2,0,0,0,0,0,0,0,0);
      c_exori = cw(0,0,0,0,0,0,1,2,1,2,0,0,0,0,0,0);
      c_ebeq  = cw(0,0,0,0,0,1,1,0,0,1,1,0,0,0,0,0);
      c_ebne  = cw(0,0,0,0,0,1,1,0,0,1,1,1,0,0,0,0);
      c_ejr   = cw(0,0,0,0,1,3,0,0,0,0,0,0,0,0,0,0);
      c_mlw   = cw(1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      c_msw   = cw(1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0);
      c_mrst  = cw(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      c_wbr   = cw(0,0,0,0,0,0,0,0,0,0,0,0,1,1,0,0);
      c_wblw  = cw(0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,0);
      c_wbi   = cw(0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0);
      c_trap  = cw(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);

      fde(I_ADD, c_eadd);
      add(0, I_ADD, 1, c_wbr, 1);
      // LW: 2 fetch waits, 3 mem waits, mem_ready low where ignored
      add(0, I_LW, 0, c_f0, 0);
      add(0, I_LW, 0, c_f0, 0);
      add(0, I_LW, 1, c_f1, 0);
      add(0, I_LW, 0, c_d, 0);
      add(0, I_LW, 0, c_eimm, 0);
      add(0, I_LW, 0, c_mlw, 0);
      add(0, I_LW, 0, c_mlw, 0);
      add(0, I_LW, 0, c_mlw, 0);
      add(0, I_LW, 1, c_mlw, 0);
      add(0, I_LW, 0, c_wblw, 1);
      fde(I_BNE, c_ebne);
      tbl[$].ret = 1;
      fde(I_BEQ, c_ebeq);
      tbl[$].ret = 1;
      add(0, I_JAL, 1, c_f1, 0);
      add(0, I_JAL, 0, c_djal, 1);
      add(0, I_J, 1, c_f1, 0);
      add(0, I_J, 1, c_dj, 1);
      fde(I_JR, c_ejr);
      tbl[$].ret = 1;
      fde(I_SW, c_eimm);
      add(0, I_SW, 0, c_msw, 0);
      add(0, I_SW, 1, c_msw, 1);
      fde(I_ADDI, c_eimm);
      add(0, I_ADDI, 1, c_wbi, 1);
      fde(I_XORI, c_exori);
      add(0, I_XORI, 0, c_wbi, 1);
      fde(I_SUB, c_esub);
      add(0, I_SUB, 1, c_wbr, 1);
      fde(I_SLT, c_eslt);
      add(0, I_SLT, 1, c_wbr, 1);
      // reset lands in MEM of SW while memory is ready
      fde(I_SW, c_eimm);
      add(1, I_SW, 1, c_mrst, 0);
      add(0, I_BAD, 1, c_f1, 0);
      add(0, I_BAD, 1, c_d, 0);
      for (int k = 0; k < 20; k++)
         add(0, I_BAD, 1'($urandom_range(0, 1)), c_trap, 0);
      add(1, I_BAD, 1, c_trap, 0);
      add(0, I_ADDU, 1, c_f1, 0);
      add(0, I_ADDU, 1, c_d, 0);
      add(0, I_ADDU, 1, c_trap, 0);
      add(0, I_ADDU, 1, c_trap, 0);
      add(1, I_ADDU, 1, c_trap, 0);
      add(0, I_ADD, 1, c_f1, 0);

      rst = 1'b1;
      rst2 = 1'b1;
      bus1.instr = I_ADD;
      bus1.mem_ready = 1'b1;
      bus2.instr = I_LW;
      bus2.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      ecyc = 0;
      eic = 0;

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         rst = tbl[k].rst;
         bus1.instr = tbl[k].ins;
         bus1.mem_ready = tbl[k].rdy;
         e.ctl = tbl[k].ctl;
         e.cyc = ecyc;
         e.ic = eic;
         e.row = k;
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         check("ctl", e.row, 32'(act1), 32'(e.ctl));
         check("cycle_count", e.row, bus1.cycle_count, e.cyc);
         check("instr_count", e.row, bus1.instr_count, e.ic);
         if (tbl[k].rst) begin
            ecyc = 0;
            eic = 0;
         end else begin
            ecyc = ecyc + 1;
            eic = eic + 32'(tbl[k].ret);
         end
      end

      // MEM_HANDSHAKE=0: mem_ready low must not stall anything
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      check("nohs_ir_we", 0, 32'(bus2.ir_we), 32'd1);
      n = 0;
      while (bus2.instr_count == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("nohs_lw_latency", 0, 32'(n), 32'd5);
      check("nohs_cycles", 0, bus2.cycle_count, 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
